// File: rtl/pt2262_encoder.sv
// PT2262-compatible trinary serial encoder: 12 code symbols + sync per 512-cycle frame.
// Define PT2262_MIN_FRAMES_EN to force every burst to at least MIN_FRAMES frames.
module pt2262_encoder #(
    parameter int MIN_FRAMES = 4
) (
    input  logic        osc_clk,
    input  logic        reset,
    input  logic        te,
    input  logic [15:0] addr_i,
    input  logic [3:0]  data_i,
    output logic        cod_o,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {S_IDLE, S_BIT, S_SYNC} state_e;

    localparam logic [1:0] SYM_0 = 2'd0;
    localparam logic [1:0] SYM_1 = 2'd1;
    localparam logic [1:0] SYM_F = 2'd2;

    if (MIN_FRAMES < 1 || MIN_FRAMES > 255) begin : g_bad_min_frames
        $error("pt2262_encoder: MIN_FRAMES must be 1..255");
    end

    state_e           state_q, state_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [11:0][1:0] frame_q, frame_d;
    logic             cod_q, cod_d;
    logic             busy_q, busy_d;
    logic             last_c, start_c, cont_c;

    // Symbol order on the wire: pins 0..7, then data[3]..data[0].
    function automatic logic [11:0][1:0] pack_frame(input logic [15:0] a, input logic [3:0] d);
        logic [11:0][1:0] f;
        for (int k = 0; k < 8; k++) begin
            case (a[2*k +: 2])
                2'b00:   f[k] = SYM_0;
                2'b11:   f[k] = SYM_1;
                default: f[k] = SYM_F;
            endcase
        end
        for (int j = 0; j < 4; j++) f[8+j] = d[3-j] ? SYM_1 : SYM_0;
        return f;
    endfunction

    function automatic logic wave(input state_e st, input logic [6:0] c, input logic [1:0] sym);
        logic [6:0] hi_a, hi_b;
        logic       w;
        hi_a = (sym == SYM_1) ? 7'd12 : 7'd4;
        hi_b = (sym == SYM_0) ? 7'd20 : 7'd28;
        case (st)
            S_BIT:   w = (c < hi_a) || ((c >= 7'd16) && (c < hi_b));
            S_SYNC:  w = (c < 7'd4);
            default: w = 1'b0;
        endcase
        return w;
    endfunction

    assign last_c = (state_q == S_SYNC) && (cnt_q == 7'd127);

`ifdef PT2262_MIN_FRAMES_EN
    logic [7:0] frames_q, frames_d;

    // Counts completed frames including the one ending this cycle.
    assign cont_c = te || ((int'(frames_q) + 1) < MIN_FRAMES);

    always_comb begin
        frames_d = frames_q;
        if (start_c && (state_q == S_IDLE)) frames_d = '0;
        else if (last_c && (frames_q != 8'hFF)) frames_d = frames_q + 8'd1;
    end

    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) frames_q <= '0;
        else       frames_q <= frames_d;
    end
`else
    assign cont_c = te;
`endif

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        frame_d   = frame_q;
        start_c   = 1'b0;
        case (state_q)
            S_IDLE: start_c = te;
            S_BIT: begin
                if (cnt_q == 7'd31) begin
                    cnt_d = '0;
                    if (bit_idx_q == 4'd11) state_d = S_SYNC;
                    else                    bit_idx_d = bit_idx_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_SYNC: begin
                if (last_c) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    if (cont_c) start_c = 1'b1;
                    else        state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (start_c) begin
            state_d   = S_BIT;
            bit_idx_d = '0;
            cnt_d     = '0;
            frame_d   = pack_frame(addr_i, data_i);
        end
        // Output is computed from the next state so cod_o is a clean flop.
        cod_d  = wave(state_d, cnt_d, frame_d[bit_idx_d]);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_idx_q <= '0;
            cnt_q     <= '0;
            frame_q   <= '0;
            cod_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            cod_q     <= cod_d;
            busy_q    <= busy_d;
        end
    end

    assign cod_o      = cod_q;
    assign busy       = busy_q;
    assign frame_done = last_c;

endmodule

// File: tb/tb_pt2262_encoder.sv
// Directed bench for pt2262_encoder; expectations follow PT2262_MIN_FRAMES_EN if defined.
module tb_pt2262_encoder;

    logic        osc_clk = 1'b0;
    logic        reset;
    logic        te;
    logic [15:0] addr_i;
    logic [3:0]  data_i;
    logic        cod_o, busy, frame_done;

    int tests = 0;
    int fails = 0;

    logic cod_log  [0:2199];
    logic busy_log [0:2199];
    logic fd_log   [0:2199];

    pt2262_encoder #(.MIN_FRAMES(4)) dut (
        .osc_clk    (osc_clk),
        .reset      (reset),
        .te         (te),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .cod_o      (cod_o),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 osc_clk = ~osc_clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Symbol codes: 0 -> '0', 1 -> '1', 2 -> 'F'
    function automatic logic exp_bit(input int s, input int c);
        case (s)
            0:       return (c < 4) || (c >= 16 && c < 20);
            1:       return (c < 12) || (c >= 16 && c < 28);
            default: return (c < 4) || (c >= 16 && c < 28);
        endcase
    endfunction

    function automatic int frame_errs(input int base, input int s[12]);
        int e = 0;
        for (int i = 0; i < 12; i++)
            for (int c = 0; c < 32; c++)
                if (cod_log[base + i*32 + c] !== exp_bit(s[i], c)) e++;
        for (int c = 0; c < 128; c++)
            if (cod_log[base + 384 + c] !== (c < 4)) e++;
        return e;
    endfunction

    task automatic run_log(input logic [15:0] a, input logic [3:0] d0, input logic [3:0] d1,
                           input int chg_k, input int te_n, input int n);
        @(negedge osc_clk);
        addr_i = a; data_i = d0; te = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge osc_clk);
            @(negedge osc_clk);
            cod_log[k] = cod_o; busy_log[k] = busy; fd_log[k] = frame_done;
            if (k + 1 >= te_n) te = 1'b0;
            if (k + 1 == chg_k) data_i = d1;
        end
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        te = 1'b0;
        while (busy === 1'b1 && cyc < 3000) begin
            @(negedge osc_clk);
            cyc++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s idle timeout: busy=%b after %0d cycles, required 0", name, busy, cyc);
        end
        repeat (3) @(negedge osc_clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; te = 1'b0; addr_i = '0; data_i = '0;
        repeat (3) @(negedge osc_clk);
        tests++;
        if ({cod_o, busy, frame_done} !== 3'b000) begin
            fails++;
            $display("FAIL reset_outputs: got %b, required 000", {cod_o, busy, frame_done});
        end
        reset = 1'b0;
        repeat (2) @(negedge osc_clk);
        tests++;
        if ({cod_o, busy, frame_done} !== 3'b000) begin
            fails++;
            $display("FAIL idle_after_reset: got %b, required 000", {cod_o, busy, frame_done});
        end
    endtask

    task automatic test_all_ones();
        int s[12];
        int e;
        for (int i = 0; i < 12; i++) s[i] = 1;
        run_log(16'hFFFF, 4'hF, 4'hF, -1, 512, 520);
        e = frame_errs(0, s);
        tests++;
        if (e !== 0) begin
            fails++;
            $display("FAIL all_ones_wave: %0d cycles differ, required 0", e);
        end
        tests++;
        if ({busy_log[0], cod_log[0], fd_log[510], fd_log[511]} !== 4'b1101) begin
            fails++;
            $display("FAIL all_ones_timing: busy0/cod0/fd510/fd511 = %b, required 1101",
                     {busy_log[0], cod_log[0], fd_log[510], fd_log[511]});
        end
        wait_idle("all_ones");
    endtask

    task automatic test_pin0_float();
        int s[12];
        int e;
        for (int i = 0; i < 12; i++) s[i] = 0;
        s[0] = 2; s[11] = 1;
        run_log(16'h0002, 4'b0001, 4'b0001, -1, 1, 520);
        e = frame_errs(0, s);
        tests++;
        if (e !== 0) begin
            fails++;
            $display("FAIL pin0_float_wave: %0d cycles differ, required 0", e);
        end
        wait_idle("pin0_float");
    endtask

    task automatic test_data_change();
        int s1[12], s2[12];
        int e1, e2, nb;
        for (int i = 0; i < 12; i++) begin s1[i] = 0; s2[i] = 0; end
        s2[8] = 1; s2[10] = 1;
        run_log(16'h0000, 4'h0, 4'hA, 200, 1024, 1030);
        e1 = frame_errs(0, s1);
        e2 = frame_errs(512, s2);
        nb = 0;
        for (int k = 0; k < 1024; k++) if (busy_log[k] !== 1'b1) nb++;
        tests++;
        if (e1 !== 0) begin
            fails++;
            $display("FAIL data_change_frame1: %0d cycles differ, required 0", e1);
        end
        tests++;
        if (e2 !== 0) begin
            fails++;
            $display("FAIL data_change_frame2: %0d cycles differ, required 0", e2);
        end
        tests++;
        if (nb !== 0 || cod_log[512] !== 1'b1) begin
            fails++;
            $display("FAIL back_to_back_gap: busy-low cycles=%0d cod512=%b, required 0 and 1", nb, cod_log[512]);
        end
        tests++;
        if ({fd_log[511], fd_log[1023]} !== 2'b11) begin
            fail_note: begin end
            fails++;
            $display("FAIL data_change_done: fd511/fd1023=%b, required 11", {fd_log[511], fd_log[1023]});
        end
        wait_idle("data_change");
    endtask

    task automatic test_reset_mid();
        int e = 0;
        run_log(16'h0000, 4'h0, 4'h0, -1, 100000, 101);
        reset = 1'b1;
        #1;
        tests++;
        if ({cod_o, busy, frame_done} !== 3'b000) begin
            fails++;
            $display("FAIL reset_mid_async: got %b, required 000", {cod_o, busy, frame_done});
        end
        repeat (2) @(negedge osc_clk);
        addr_i = 16'h0003;
        reset = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(posedge osc_clk);
            @(negedge osc_clk);
            cod_log[k] = cod_o; busy_log[k] = busy;
            if (cod_o !== exp_bit(1, k) || busy !== 1'b1) e++;
        end
        tests++;
        if (e !== 0) begin
            fails++;
            $display("FAIL reset_restart_sym0: %0d cycles differ, required 0", e);
        end
        wait_idle("reset_mid");
    endtask

`ifdef PT2262_MIN_FRAMES_EN
    task automatic test_min_frames();
        int s[12];
        int nb, nfd, e;
        for (int i = 0; i < 12; i++) s[i] = 0;
        run_log(16'h0000, 4'h0, 4'h0, -1, 1, 2100);
        nb = 0; nfd = 0;
        for (int k = 0; k < 2100; k++) begin
            if (busy_log[k] === 1'b1) nb++;
            if (fd_log[k] === 1'b1) nfd++;
        end
        tests++;
        if (nb !== 2048 || busy_log[2047] !== 1'b1 || busy_log[2048] !== 1'b0) begin
            fails++;
            $display("FAIL min_frames_busy: busy cycles=%0d, required 2048", nb);
        end
        tests++;
        if (nfd !== 4 || {fd_log[511], fd_log[1023], fd_log[1535], fd_log[2047]} !== 4'hF) begin
            fails++;
            $display("FAIL min_frames_done: pulses=%0d, required 4 at 511/1023/1535/2047", nfd);
        end
        for (int f = 0; f < 4; f++) begin
            e = frame_errs(f * 512, s);
            tests++;
            if (e !== 0) begin
                fails++;
                $display("FAIL min_frames_wave%0d: %0d cycles differ, required 0", f, e);
            end
        end
        wait_idle("min_frames");
    endtask
`else
    task automatic test_single_pulse();
        int s[12];
        int nb, nfd, e;
        for (int i = 0; i < 12; i++) s[i] = 0;
        run_log(16'h0000, 4'h0, 4'h0, -1, 1, 700);
        nb = 0; nfd = 0;
        for (int k = 0; k < 700; k++) begin
            if (busy_log[k] === 1'b1) nb++;
            if (fd_log[k] === 1'b1) nfd++;
        end
        tests++;
        if (nb !== 512 || busy_log[512] !== 1'b0) begin
            fails++;
            $display("FAIL single_pulse_busy: busy cycles=%0d busy512=%b, required 512 and 0", nb, busy_log[512]);
        end
        tests++;
        if (nfd !== 1 || fd_log[511] !== 1'b1) begin
            fails++;
            $display("FAIL single_pulse_done: pulses=%0d fd511=%b, required 1 and 1", nfd, fd_log[511]);
        end
        e = frame_errs(0, s);
        tests++;
        if (e !== 0) begin
            fails++;
            $display("FAIL single_pulse_wave: %0d cycles differ, required 0", e);
        end
        wait_idle("single_pulse");
    endtask
`endif

    initial begin
        test_reset();
        test_all_ones();
        test_pin0_float();
        test_data_change();
        test_reset_mid();
`ifdef PT2262_MIN_FRAMES_EN
        test_min_frames();
`else
        test_single_pulse();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pt2262_encoder.md
# pt2262_encoder

PT2262-compatible serial encoder: the transmit-side stage that produces the `cod_i` stream consumed by the PT2272 decoder. It latches an 8-pin trinary address and a 4-bit data word, then emits frames on `cod_o` while transmission is enabled. Each frame is 12 code bits followed by a sync bit. The block runs on the oscillator clock, and one `osc_clk` period equals one α (the PT2262 oscillator period).

## Interface
Parameters:
- `MIN_FRAMES`, default 4: minimum frames per burst. Used only when `PT2262_MIN_FRAMES_EN` is defined. Legal range 1..255.

Ports:
- `osc_clk`, input, 1: encoder clock; 1 period = 1α.
- `reset`, input, 1: reset, asynchronous, active-high.
- `te`, input, 1: transmit enable, active-high, sampled on `osc_clk`.
- `addr_i`, input, 16: trinary address, one pair per pin. Pin k = {addr_i[2k+1], addr_i[2k]}: 00 → 0, 11 → 1, 10 or 01 → F.
- `data_i`, input, 4: data bits; binary only.
- `cod_o`, output, 1: registered encoded serial output.
- `busy`, output, 1: high while a frame is being emitted.
- `frame_done`, output, 1: one-cycle pulse during the last cycle of each frame.

## Operation
- FSM states:
  - IDLE: `cod_o` = 0, `busy` = 0.
  - BIT: emits a code bit. Bit counter `bit_idx` runs 0..11; cycle counter `cnt` runs 0..31.
  - SYNC: `cnt` runs 0..127.
- Symbol waveforms, in cycles (H = `cod_o` high, L = low):
  - 0 = H4 L12 H4 L12
  - 1 = H12 L4 H12 L4
  - F = H4 L12 H12 L4
  - sync = H4 L124
- Frame length: 12×32 + 128 = 512 cycles.
- Transmission order, 12 symbols then sync: pin 0 … pin 7, then `data_i[3]`, `data_i[2]`, `data_i[1]`, `data_i[0]`, then sync. This places data[0] directly before sync, matching the decoder's shift order.
- IDLE → BIT: when `te` = 1 at an edge in IDLE. On that same edge:
  - `addr_i` and `data_i` are latched into a 12-symbol frame register.
  - `bit_idx` = 0, `cnt` = 0.
- BIT:
  - When `cnt` = 31 and `bit_idx` < 11: `bit_idx` increments, `cnt` = 0.
  - When `cnt` = 31 and `bit_idx` = 11: go to SYNC, `cnt` = 0.
- SYNC, at `cnt` = 127 (the last frame cycle, `frame_done` = 1):
  - Continue condition true: relatch the inputs and go to BIT, `bit_idx` = 0, `cnt` = 0. Frames are back-to-back with no gap cycle.
  - Otherwise go to IDLE.
- Continue condition: `te` = 1 at that edge, or the minimum-burst condition (see Configuration).
- Input changes mid-frame have no effect on the current frame; they apply at the next frame latch.
- `te` dropping mid-frame never truncates a frame; the current frame always completes.
- Symbol mapping: 00 → 0, 11 → 1, 01 or 10 → F. There is no illegal encoding.

## Timing
- Reset values: `cod_o` = 0, `busy` = 0, `frame_done` = 0; state IDLE, all counters 0, burst counter 0.
- Reset asserted mid-frame: all outputs go to 0 asynchronously and the frame is abandoned. After reset deasserts, transmission restarts only on a new `te` sample.
- Latency: `cod_o` and `busy` rise on the same edge that samples `te` = 1 in IDLE. That edge begins cycle 0 of symbol 0.
- `cod_o` is a registered function of the next state, next `cnt` and the current symbol, so it has no combinational glitches.
- `busy` falls on the edge leaving SYNC into IDLE; `cod_o` is already 0 there, since the sync tail is low.
- `frame_done` is high exactly when state = SYNC and `cnt` = 127, i.e. one cycle per frame.
- Burst frame counter is 8 bits and saturates at 255. It clears when leaving IDLE.

## Configuration
- Macro: `PT2262_MIN_FRAMES_EN`.
- Defined:
  - Each burst emits at least `MIN_FRAMES` frames, even if `te` is a single-cycle pulse.
  - Continue condition = `te` OR (frames completed in this burst < `MIN_FRAMES`).
- Undefined:
  - The burst counter logic is not compiled in.
  - Continue condition = `te` only; a 1-cycle `te` pulse produces exactly one frame.

## Test plan
- Macro defined, `MIN_FRAMES` = 4; `addr_i` = 16'h0000, `data_i` = 4'h0; `te` pulsed for 1 cycle → `busy` high for exactly 2048 cycles, four `frame_done` pulses 512 cycles apart. Every code bit is H4 L12 H4 L12; each sync is H4 L124.
- `addr_i` = 16'hFFFF, `data_i` = 4'hF, `te` held high for one frame → all 12 symbols are H12 L4 H12 L4, followed by H4 L124.
- `addr_i` = 16'h0002 (pin 0 = F), `data_i` = 4'b0001 → symbol 0 is H4 L12 H12 L4. Symbols 1–10 are 0-waveforms; symbol 11 (`data_i[0]`) is a 1-waveform.
- `te` held high; `data_i` changes 4'h0 → 4'hA at cycle 200 of frame 1 → frame 1 still carries 0. Frame 2 starts at cycle 512 with no gap and carries D3..D0 = 1,0,1,0.
- `reset` asserted at cycle 100 of a frame → `cod_o`, `busy` and `frame_done` are 0 immediately. After release with `te` = 1, a fresh frame starts at symbol 0, `cnt` 0.
- Macro undefined; `te` pulsed for 1 cycle → exactly one 512-cycle frame, one `frame_done`, and `busy` low at cycle 512.
